// File: rtl/lfsr_seq_ctrl.sv
// Sequencer/arbiter for an external LFSR: round-robin service of two requesters,
// STEPS advances per delivered word, seed ownership and all-zero lockup recovery.
module lfsr_seq_ctrl #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      STEPS = 4,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hA5)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    input  logic             seed_wr,
    input  logic [WIDTH-1:0] seed_in,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_en,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic             busy,
    output logic [7:0]       lockup_cnt
);

    localparam int unsigned CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned LOCK_W = 8;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RESEED,
        S_STEP,
        S_CHECK,
        S_RELOAD,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic [LOCK_W-1:0]  lockup_q, lockup_d;
    logic [WIDTH-1:0]   seed_q, seed_d;
    logic               rr_last_q, rr_last_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   pend_val_q, pend_val_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic               win_idx;

    // An all-zero seed would lock the LFSR, so it is replaced by SEED
    function automatic logic [WIDTH-1:0] fix_seed(input logic [WIDTH-1:0] v);
        return (v == '0) ? SEED : v;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_INIT;
            gnt_q      <= 2'b00;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            lockup_q   <= '0;
            seed_q     <= SEED;
            rr_last_q  <= 1'b1;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            lockup_q   <= lockup_d;
            seed_q     <= seed_d;
            rr_last_q  <= rr_last_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        lockup_d   = lockup_q;
        seed_d     = seed_q;
        rr_last_d  = rr_last_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        step_cnt_d = step_cnt_q;
        win_idx    = (req == 2'b11) ? ~rr_last_q : req[1];

        // Seed writes that arrive while busy are parked until the next IDLE
        if (seed_wr && (state_q != S_IDLE)) begin
            pend_d     = 1'b1;
            pend_val_d = seed_in;
        end

        case (state_q)
            S_INIT, S_RESEED: state_d = S_IDLE;
            S_IDLE: begin
                if (seed_wr) begin
                    seed_d  = fix_seed(seed_in);
                    pend_d  = 1'b0;
                    state_d = S_RESEED;
                end else if (pend_q) begin
                    seed_d  = fix_seed(pend_val_q);
                    pend_d  = 1'b0;
                    state_d = S_RESEED;
                end else if (req != 2'b00) begin
                    gnt_d      = win_idx ? 2'b10 : 2'b01;
                    step_cnt_d = '0;
                    state_d    = S_STEP;
                end
            end
            S_STEP: begin
                if (step_cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    step_cnt_d = step_cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (lfsr_q == '0) begin
                    if (lockup_q != {LOCK_W{1'b1}}) begin
                        lockup_d = lockup_q + LOCK_W'(1);
                    end
                    state_d = S_RELOAD;
                end else begin
                    rdata_d  = lfsr_q;
                    rvalid_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_RELOAD: begin
                step_cnt_d = '0;
                state_d    = S_STEP;
            end
            S_DONE: begin
                gnt_d     = 2'b00;
                rr_last_d = gnt_q[1];
                state_d   = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign lfsr_load  = (state_q == S_INIT) || (state_q == S_RESEED) || (state_q == S_RELOAD);
    assign lfsr_en    = (state_q == S_STEP);
    assign lfsr_seed  = seed_q;
    assign busy       = (state_q != S_IDLE);
    assign gnt        = gnt_q;
    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign lockup_cnt = lockup_q;

endmodule
